// File: rtl/br_flag_gen.sv
// Branch condition-flag producer: selects the branch operand across the forwarding
// paths, registers Z/P/N with the branch opcode, and requests a decode stall on load-use.
module br_flag_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_op,
    input  logic [2:0]       id_rs,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic             ex_wr_en,
    input  logic [2:0]       ex_wr_reg,
    input  logic             ex_is_load,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             mem_wr_en,
    input  logic [2:0]       mem_wr_reg,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             stall_in,
    input  logic             flush,
    output logic             stall_req,
    output logic             br_valid,
    output logic [4:0]       br_op,
    output logic             Z,
    output logic             P,
    output logic             N
);

    localparam int unsigned OP_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] BR_CLASS = 3'b011;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [OP_W-1:0] pend_op_q;
    logic [OP_W-1:0] pend_op_d;

    logic            br_valid_d;
    logic [OP_W-1:0] br_op_d;
    logic            z_d;
    logic            p_d;
    logic            n_d;

    logic            is_branch;
    logic            ex_hit;
    logic            mem_hit;
    logic            load_use;
    logic [WIDTH-1:0] operand;

    logic            capture;
    logic [WIDTH-1:0] src;
    logic [OP_W-1:0] src_op;

    // Decode classification, forwarding select and load-use detection
    always_comb begin
        is_branch = id_valid & (id_op[4:2] == BR_CLASS);
        ex_hit    = ex_wr_en & ~ex_is_load & (ex_wr_reg == id_rs);
        mem_hit   = mem_wr_en & (mem_wr_reg == id_rs);
        load_use  = is_branch & ex_wr_en & ex_is_load & (ex_wr_reg == id_rs);
        if (ex_hit) begin
            operand = ex_result;
        end else if (mem_hit) begin
            operand = mem_result;
        end else begin
            operand = id_rs_data;
        end
    end

    // Only a fresh decode in IDLE can raise the stall; flush squashes the request
    assign stall_req = (state_q == ST_IDLE) & ~flush & load_use;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pend_op_d  = pend_op_q;
        br_valid_d = br_valid;
        br_op_d    = br_op;
        z_d        = Z;
        p_d        = P;
        n_d        = N;
        capture    = 1'b0;
        src        = operand;
        src_op     = id_op;

        if (flush) begin
            state_d    = ST_IDLE;
            br_valid_d = 1'b0;
            br_op_d    = '0;
            z_d        = 1'b0;
            p_d        = 1'b0;
            n_d        = 1'b0;
        end else if (!stall_in) begin
            br_valid_d = 1'b0;
            br_op_d    = '0;
            z_d        = 1'b0;
            p_d        = 1'b0;
            n_d        = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_use) begin
                        pend_op_d = id_op;
                        state_d   = ST_WAIT;
                    end else if (is_branch) begin
                        capture = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The load has moved to MEM; its data is the operand
                    capture = 1'b1;
                    src     = mem_result;
                    src_op  = pend_op_q;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (capture) begin
                br_valid_d = 1'b1;
                br_op_d    = src_op;
                z_d        = (src == '0);
                n_d        = src[WIDTH-1];
                p_d        = (src != '0) & ~src[WIDTH-1];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_op_q <= '0;
            br_valid  <= 1'b0;
            br_op     <= '0;
            Z         <= 1'b0;
            P         <= 1'b0;
            N         <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_op_q <= pend_op_d;
            br_valid  <= br_valid_d;
            br_op     <= br_op_d;
            Z         <= z_d;
            P         <= p_d;
            N         <= n_d;
        end
    end

endmodule
